// File: rtl/s_axi_wr_slave_if.sv
// AXI3-style write channel bundle (AW, W, B) between a master and s_axi_wr_slave.
// Signal names carry the slave-side direction suffix so both ends share one naming.
interface s_axi_wr_slave_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32
);
    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    logic [3:0]            awid_i;
    logic [7:0]            awlen_i;
    logic [2:0]            awsize_i;
    logic [1:0]            awburst_i;
    logic [ADDR_WIDTH-1:0] awaddr_i;
    logic                  awvalid_i;
    logic                  awready_o;

    logic [3:0]            wid_i;
    logic [DATA_WIDTH-1:0] wdata_i;
    logic [STRB_WIDTH-1:0] wstrb_i;
    logic                  wlast_i;
    logic                  wvalid_i;
    logic                  wready_o;

    logic [3:0]            bid_o;
    logic [1:0]            bresp_o;
    logic                  bvalid_o;
    logic                  bready_i;

    modport slave (
        input  awid_i, awlen_i, awsize_i, awburst_i, awaddr_i, awvalid_i,
        output awready_o,
        input  wid_i, wdata_i, wstrb_i, wlast_i, wvalid_i,
        output wready_o,
        output bid_o, bresp_o, bvalid_o,
        input  bready_i
    );

    modport master (
        output awid_i, awlen_i, awsize_i, awburst_i, awaddr_i, awvalid_i,
        input  awready_o,
        output wid_i, wdata_i, wstrb_i, wlast_i, wvalid_i,
        input  wready_o,
        input  bid_o, bresp_o, bvalid_o,
        output bready_i
    );
endinterface

// File: rtl/s_axi_wr_slave.sv
// Single-outstanding AXI write slave backed by a register-file memory with a debug read port.
// Bad bursts are fully consumed and answered with SLVERR; illegal beats never touch memory.
module s_axi_wr_slave #(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           MEM_DEPTH  = 64,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                         clk,
    input  logic                         areset,
    s_axi_wr_slave_if.slave              bus,
    input  logic [$clog2(MEM_DEPTH)-1:0] mem_raddr_i,
    output logic [DATA_WIDTH-1:0]        mem_rdata_o,
    output logic [15:0]                  burst_count_o
);
    localparam int unsigned STRB_W = DATA_WIDTH / 8;
    localparam int unsigned IDX_W  = $clog2(MEM_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_RESP = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [3:0]            id_q, id_d;
    logic [7:0]            len_q, len_d;
    logic [7:0]            beat_q, beat_d;
    logic                  fixed_q, fixed_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    logic                  aw_err_q, aw_err_d;
    logic                  err_q, err_d;

    logic                  awready_d, wready_d, bvalid_d;
    logic [3:0]            bid_d;
    logic [1:0]            bresp_d;
    logic [15:0]           bcnt_d;

    logic                  aw_hs_c, w_hs_c, b_hs_c;
    logic                  at_len_c, in_range_c, mem_we_c;

    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

    // Next-state, capture registers and next values of the registered outputs
    always_comb begin
        state_d   = state_q;
        id_d      = id_q;
        len_d     = len_q;
        beat_d    = beat_q;
        fixed_d   = fixed_q;
        idx_d     = idx_q;
        aw_err_d  = aw_err_q;
        err_d     = err_q;
        bid_d     = bus.bid_o;
        bresp_d   = bus.bresp_o;
        bcnt_d    = burst_count_o;
        mem_we_c  = 1'b0;

        aw_hs_c    = bus.awvalid_i && bus.awready_o;
        w_hs_c     = bus.wvalid_i && bus.wready_o;
        b_hs_c     = bus.bvalid_o && bus.bready_i;
        at_len_c   = (beat_q == len_q);
        in_range_c = (idx_q < ADDR_WIDTH'(MEM_DEPTH));

        case (state_q)
            S_IDLE: begin
                if (aw_hs_c) begin
                    id_d     = bus.awid_i;
                    len_d    = bus.awlen_i;
                    fixed_d  = (bus.awburst_i == 2'b00);
                    idx_d    = (bus.awaddr_i - BASE_ADDR) >> 2;
                    beat_d   = 8'd0;
                    aw_err_d = (bus.awsize_i != 3'd2) || bus.awburst_i[1] ||
                               (bus.awaddr_i[1:0] != 2'b00);
                    err_d    = aw_err_d;
                    state_d  = S_DATA;
                end
            end
            S_DATA: begin
                if (w_hs_c) begin
                    mem_we_c = !aw_err_q && in_range_c;
                    err_d    = err_q || !in_range_c || (bus.wid_i != id_q) ||
                               (bus.wlast_i != at_len_c);
                    beat_d   = beat_q + 8'd1;
                    if (!fixed_q) idx_d = idx_q + ADDR_WIDTH'(1);
                    if (bus.wlast_i || at_len_c) begin
                        state_d = S_RESP;
                        bid_d   = id_q;
                        bresp_d = err_d ? 2'b10 : 2'b00;
                    end
                end
            end
            S_RESP: begin
                if (b_hs_c) begin
                    state_d = S_IDLE;
                    bcnt_d  = burst_count_o + 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        awready_d = (state_d == S_IDLE);
        wready_d  = (state_d == S_DATA);
        bvalid_d  = (state_d == S_RESP);
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q       <= S_IDLE;
            id_q          <= '0;
            len_q         <= '0;
            beat_q        <= '0;
            fixed_q       <= 1'b0;
            idx_q         <= '0;
            aw_err_q      <= 1'b0;
            err_q         <= 1'b0;
            bus.awready_o <= 1'b0;
            bus.wready_o  <= 1'b0;
            bus.bvalid_o  <= 1'b0;
            bus.bid_o     <= '0;
            bus.bresp_o   <= 2'b00;
            burst_count_o <= '0;
        end else begin
            state_q       <= state_d;
            id_q          <= id_d;
            len_q         <= len_d;
            beat_q        <= beat_d;
            fixed_q       <= fixed_d;
            idx_q         <= idx_d;
            aw_err_q      <= aw_err_d;
            err_q         <= err_d;
            bus.awready_o <= awready_d;
            bus.wready_o  <= wready_d;
            bus.bvalid_o  <= bvalid_d;
            bus.bid_o     <= bid_d;
            bus.bresp_o   <= bresp_d;
            burst_count_o <= bcnt_d;
        end
    end

    // Storage with byte-lane writes; the debug read samples pre-write contents
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            for (int unsigned i = 0; i < MEM_DEPTH; i++) mem_q[i] <= '0;
            mem_rdata_o <= '0;
        end else begin
            mem_rdata_o <= mem_q[mem_raddr_i];
            if (mem_we_c) begin
                for (int unsigned b = 0; b < STRB_W; b++) begin
                    if (bus.wstrb_i[b]) mem_q[idx_q[IDX_W-1:0]][b*8 +: 8] <= bus.wdata_i[b*8 +: 8];
                end
            end
        end
    end
endmodule

// File: tb/tb_s_axi_wr_slave.sv
// Randomized self-checking bench for s_axi_wr_slave against a burst-level memory model.
module tb_s_axi_wr_slave;
    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 32;
    localparam int unsigned DEPTH = 64;

    logic        clk = 1'b0;
    logic        areset;
    logic [5:0]  mem_raddr;
    logic [31:0] mem_rdata;
    logic [15:0] burst_count;

    s_axi_wr_slave_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    s_axi_wr_slave #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_DEPTH(DEPTH), .BASE_ADDR(32'h0)
    ) dut (
        .clk          (clk),
        .areset       (areset),
        .bus          (bus.slave),
        .mem_raddr_i  (mem_raddr),
        .mem_rdata_o  (mem_rdata),
        .burst_count_o(burst_count)
    );

    always #5 clk = ~clk;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    logic [31:0] model_mem [DEPTH];
    logic [15:0] model_cnt;
    logic [31:0] beat_data [256];
    logic [3:0]  beat_strb [256];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
        model_cnt = '0;
    endtask

    task automatic check_mem(input string tag);
        for (int w = 0; w < DEPTH; w++) begin
            mem_raddr = 6'(w);
            @(negedge clk);
            chk($sformatf("%s_mem[%0d]", tag, w), mem_rdata, model_mem[w]);
        end
    endtask

    task automatic idle_bus();
        bus.awvalid_i = 1'b0; bus.awid_i = '0; bus.awlen_i = '0; bus.awsize_i = 3'd2;
        bus.awburst_i = 2'b01; bus.awaddr_i = '0;
        bus.wvalid_i = 1'b0; bus.wid_i = '0; bus.wdata_i = '0; bus.wstrb_i = '0; bus.wlast_i = 1'b0;
        bus.bready_i = 1'b0;
    endtask

    // One complete burst; wlast_at/bad_wid_beat may deliberately disagree with the AW fields
    task automatic run_burst(input logic [3:0] id, input logic [7:0] len, input logic [2:0] size,
                             input logic [1:0] burst, input logic [31:0] addr,
                             input int wlast_at, input int bad_wid_beat,
                             input int bready_delay, input bit gaps);
        int          n;
        int          beats;
        bit          aw_err, err;
        logic [31:0] base_idx, idx;
        logic [1:0]  exp_resp;

        aw_err   = (size != 3'd2) || (burst[1] == 1'b1) || (addr[1:0] != 2'b00);
        err      = aw_err || (wlast_at != int'(len));
        beats    = ((wlast_at < int'(len)) ? wlast_at : int'(len)) + 1;
        base_idx = addr >> 2;

        @(negedge clk);
        bus.awid_i = id; bus.awlen_i = len; bus.awsize_i = size;
        bus.awburst_i = burst; bus.awaddr_i = addr; bus.awvalid_i = 1'b1;
        n = 0;
        while (!bus.awready_o && n < 20) begin @(negedge clk); n++; end
        if (n == 20) begin chk("awready_timeout", 32'd0, 32'd1); bus.awvalid_i = 1'b0; return; end
        @(negedge clk);
        bus.awvalid_i = 1'b0;
        chk("wready_after_aw", 32'(bus.wready_o), 32'd1);
        chk("awready_in_data", 32'(bus.awready_o), 32'd0);

        for (int k = 0; k < beats; k++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                bus.wvalid_i = 1'b0;
                repeat ($urandom_range(1, 2)) @(negedge clk);
            end
            bus.wvalid_i = 1'b1;
            bus.wdata_i  = beat_data[k];
            bus.wstrb_i  = beat_strb[k];
            bus.wid_i    = (k == bad_wid_beat) ? (id ^ 4'h1) : id;
            bus.wlast_i  = (k == wlast_at);
            n = 0;
            while (!bus.wready_o && n < 20) begin @(negedge clk); n++; end
            chk("beat_ready", 32'(n), 32'd0);
            if (n == 20) begin bus.wvalid_i = 1'b0; return; end
            idx = base_idx + ((burst == 2'b00) ? 32'd0 : 32'(k));
            if (k == bad_wid_beat) err = 1'b1;
            if (idx >= DEPTH) err = 1'b1;
            else if (!aw_err) begin
                for (int b = 0; b < 4; b++)
                    if (beat_strb[k][b]) model_mem[idx][b*8 +: 8] = beat_data[k][b*8 +: 8];
            end
            @(negedge clk);
        end
        bus.wvalid_i = 1'b0;
        bus.wlast_i  = 1'b0;

        exp_resp = err ? 2'b10 : 2'b00;
        chk("wready_in_resp", 32'(bus.wready_o), 32'd0);
        for (int d = 0; d <= bready_delay; d++) begin
            chk("bvalid", 32'(bus.bvalid_o), 32'd1);
            chk("bid", 32'(bus.bid_o), 32'(id));
            chk("bresp", 32'(bus.bresp_o), 32'(exp_resp));
            if (d < bready_delay) @(negedge clk);
        end
        bus.bready_i = 1'b1;
        @(negedge clk);
        bus.bready_i = 1'b0;
        model_cnt = model_cnt + 16'd1;
        chk("bvalid_after_b", 32'(bus.bvalid_o), 32'd0);
        chk("awready_after_b", 32'(bus.awready_o), 32'd1);
        chk("burst_count", 32'(burst_count), 32'(model_cnt));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int len;
        idle_bus();
        mem_raddr = '0;
        model_clear();

        areset = 1'b1;
        #1;
        chk("rst_awready", 32'(bus.awready_o), 32'd0);
        chk("rst_wready", 32'(bus.wready_o), 32'd0);
        chk("rst_bvalid", 32'(bus.bvalid_o), 32'd0);
        chk("rst_bid", 32'(bus.bid_o), 32'd0);
        chk("rst_bresp", 32'(bus.bresp_o), 32'd0);
        chk("rst_rdata", mem_rdata, 32'd0);
        chk("rst_count", 32'(burst_count), 32'd0);
        repeat (3) @(negedge clk);
        areset = 1'b0;
        @(negedge clk);
        chk("awready_first_edge", 32'(bus.awready_o), 32'd1);

        // INCR at word 2, four full beats
        for (int k = 0; k < 4; k++) begin beat_data[k] = 32'(k + 1); beat_strb[k] = 4'hF; end
        run_burst(4'd5, 8'd3, 3'd2, 2'b01, 32'h8, 3, -1, 0, 1'b0);
        check_mem("incr");

        // FIXED at word 0: only the last beat survives
        beat_data[0] = 32'hA; beat_data[1] = 32'hB; beat_data[2] = 32'hC;
        for (int k = 0; k < 3; k++) beat_strb[k] = 4'hF;
        run_burst(4'd2, 8'd2, 3'd2, 2'b00, 32'h0, 2, -1, 0, 1'b0);
        check_mem("fixed");

        // INCR running off the end of memory
        for (int k = 0; k < 4; k++) begin beat_data[k] = 32'h1000 + 32'(k); beat_strb[k] = 4'hF; end
        run_burst(4'd7, 8'd3, 3'd2, 2'b01, 32'(4 * (DEPTH - 2)), 3, -1, 0, 1'b0);
        check_mem("overrun");

        // WRAP is unsupported: beats consumed, nothing written
        beat_data[0] = 32'hFFFF_FFFF; beat_data[1] = 32'hEEEE_EEEE;
        beat_strb[0] = 4'hF; beat_strb[1] = 4'hF;
        run_burst(4'd3, 8'd1, 3'd2, 2'b10, 32'h40, 1, -1, 0, 1'b0);
        check_mem("wrap");

        // Partial strobe: low half only
        beat_data[0] = 32'hFFFF_FFFF; beat_strb[0] = 4'hF;
        run_burst(4'd1, 8'd0, 3'd2, 2'b01, 32'h40, 0, -1, 0, 1'b0);
        beat_data[0] = 32'h1234_5678; beat_strb[0] = 4'h3;
        run_burst(4'd1, 8'd0, 3'd2, 2'b01, 32'h40, 0, -1, 5, 1'b0);
        check_mem("strb");

        // Randomized bursts with occasional protocol faults
        for (int t = 0; t < 40; t++) begin
            logic [31:0] addr;
            logic [1:0]  bt;
            logic [2:0]  sz;
            int          wl, bw;
            len  = $urandom_range(0, 7);
            addr = 32'($urandom_range(0, DEPTH + 4)) * 32'd4;
            if ($urandom_range(0, 9) == 0) addr[1:0] = 2'($urandom_range(1, 3));
            bt   = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
            sz   = ($urandom_range(0, 9) == 0) ? 3'd1 : 3'd2;
            wl   = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 8)) : len;
            bw   = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, len)) : -1;
            for (int k = 0; k < 9; k++) begin
                beat_data[k] = $urandom;
                beat_strb[k] = 4'($urandom_range(0, 15));
            end
            run_burst(4'($urandom_range(0, 15)), 8'(len), sz, bt, addr, wl, bw,
                      $urandom_range(0, 3), 1'b1);
            if (t % 10 == 9) check_mem("rand");
        end

        // Reset in the middle of a burst discards it
        for (int k = 0; k < 4; k++) begin beat_data[k] = 32'hCAFE_0000 + 32'(k); beat_strb[k] = 4'hF; end
        @(negedge clk);
        bus.awid_i = 4'd9; bus.awlen_i = 8'd3; bus.awsize_i = 3'd2;
        bus.awburst_i = 2'b01; bus.awaddr_i = 32'h10; bus.awvalid_i = 1'b1;
        @(negedge clk);
        bus.awvalid_i = 1'b0;
        for (int k = 0; k < 2; k++) begin
            bus.wvalid_i = 1'b1; bus.wid_i = 4'd9; bus.wdata_i = beat_data[k];
            bus.wstrb_i = 4'hF; bus.wlast_i = 1'b0;
            @(negedge clk);
        end
        bus.wvalid_i = 1'b0;
        areset = 1'b1;
        #1;
        chk("midrst_wready", 32'(bus.wready_o), 32'd0);
        chk("midrst_bvalid", 32'(bus.bvalid_o), 32'd0);
        chk("midrst_count", 32'(burst_count), 32'd0);
        model_clear();
        @(negedge clk);
        areset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("midrst_no_bvalid", 32'(bus.bvalid_o), 32'd0);
            chk("midrst_awready", 32'(bus.awready_o), 32'd1);
        end
        check_mem("midrst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/s_axi_wr_slave.md
S_AXI_WR_SLAVE -- requirements
Module: s_axi_wr_slave

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, data bus width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, address bus width in bits.
REQ-003 SHALL have parameter MEM_DEPTH, default 64, number of DATA_WIDTH words in internal storage.
REQ-004 SHALL have parameter BASE_ADDR, default 0, byte address of word 0.
REQ-005 SHALL have ports (one clock; reset is asynchronous and active-high):
- clk  in  1  sole clock, rising edge
- areset  in  1  asynchronous reset, active-high
- awid_i  in  4  write burst ID
- awlen_i  in  8  beats minus 1
- awsize_i  in  3  beat size code (2 = 4 bytes)
- awburst_i  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
- awaddr_i  in  ADDR_WIDTH  burst start byte address
- awvalid_i  in  1  address valid
- awready_o  out  1  address ready
- wid_i  in  4  data ID
- wdata_i  in  DATA_WIDTH  beat data
- wstrb_i  in  DATA_WIDTH/8  byte enables
- wlast_i  in  1  final beat marker
- wvalid_i  in  1  data valid
- wready_o  out  1  data ready
- bid_o  out  4  response ID
- bresp_o  out  2  00 OKAY, 10 SLVERR
- bvalid_o  out  1  response valid
- bready_i  in  1  response ready
- mem_raddr_i  in  $clog2(MEM_DEPTH)  debug read word index
- mem_rdata_o  out  DATA_WIDTH  debug read data
- burst_count_o  out  16  completed bursts

Function
REQ-006 SHALL implement FSM IDLE -> DATA -> RESP -> IDLE; one burst in flight at a time.
REQ-007 IDLE: awready_o=1, wready_o=0, bvalid_o=0; on awvalid_i&&awready_o, capture id/len/burst/addr, load word index = (awaddr_i-BASE_ADDR)>>2, clear beat counter and error flag, go to DATA.
REQ-008 At AW handshake, set error flag if awsize_i!=2, awburst_i is 10 or 11, or awaddr_i[1:0]!=0; flagged burst SHALL suppress all memory writes but still consume every beat.
REQ-009 DATA: wready_o=1, awready_o=0; each wvalid_i&&wready_o handshake is one beat.
REQ-010 Per beat: if no AW-level error and index<MEM_DEPTH, write bytes of wdata_i where wstrb_i bit is 1; other bytes unchanged.
REQ-011 Per beat: index>=MEM_DEPTH (including underflow below BASE_ADDR, unsigned) SHALL skip the write and set error flag.
REQ-012 Per beat: wid_i != captured ID SHALL set error flag; beat still written if otherwise legal.
REQ-013 Index SHALL increment by 1 per beat for INCR, hold for FIXED.
REQ-014 DATA exits to RESP on the handshake where wlast_i=1 or beat counter == captured len, whichever first; if the two disagree, set error flag.
REQ-015 RESP: bvalid_o=1, bid_o=captured ID, bresp_o=10 if error flag else 00; held stable until bready_i.
REQ-016 On bvalid_o&&bready_i: go to IDLE next cycle, burst_count_o increments, wraps 0xFFFF->0x0000.
REQ-017 Outputs awready_o/wready_o/bvalid_o/bid_o/bresp_o SHALL be registered; state change visible the cycle after the triggering handshake.
REQ-018 mem_rdata_o SHALL equal memory[mem_raddr_i] one cycle after sampling; same-cycle write and read of the same word returns pre-write data.
REQ-019 Minimum burst time SHALL be 1 AW cycle + (len+1) beat cycles + 1 response cycle; no bubbles between back-to-back beats.

Reset
REQ-020 areset high SHALL immediately force IDLE, awready_o=0, wready_o=0, bvalid_o=0, bid_o=0, bresp_o=00, mem_rdata_o=0, burst_count_o=0, all memory words 0.
REQ-021 awready_o SHALL rise on the first clk edge after areset deasserts.
REQ-022 areset mid-burst SHALL discard the burst; no response issued for it.

Verification
REQ-023 INCR awaddr=0x8, awlen=3, awid=5, data 1,2,3,4, wstrb=F -> words 2..5 = 1..4; bid=5, bresp=00; burst_count=1.
REQ-024 FIXED awaddr=0x0, awlen=2, data A,B,C -> word 0 = C, words 1..2 unchanged; bresp=00.
REQ-025 INCR awaddr=4*(MEM_DEPTH-2), awlen=3 -> last two words written, remaining beats dropped, bresp=10.
REQ-026 awburst=10 awlen=1 -> both beats accepted, memory unchanged, bresp=10; wstrb=0x3 on legal beat writes low half only.
REQ-027 bready_i held low 5 cycles in RESP -> bvalid_o/bid_o/bresp_o stable; areset pulse during DATA -> IDLE, bvalid_o never asserted, memory all 0.
